// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes and controller states.
package seq_alu_pkg;

    localparam int unsigned ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_CS_ADD      = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_CS_ADDC     = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_CS_SUB      = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_CS_AND      = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_CS_OR       = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_CS_XOR      = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_CS_SHIFT_OP = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_CS_NOP      = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_CS_MUL      = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_CS_DIV      = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative datapath: shift-add multiply and restoring divide, one step per clock.
module seq_alu_muldiv #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_last,
    output logic             o_is_div,
    output logic [WIDTH-1:0] o_res_lo,
    output logic [WIDTH-1:0] o_res_hi
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;

    logic [WIDTH:0]   mul_sum, div_shift, div_trial;
    logic [WIDTH-1:0] step_hi, step_lo;

    // lo holds the multiplier (mul) or the dividend/quotient (div); hi is the
    // partial product or the running remainder; opnd is multiplicand or divisor.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd_q};
        if (is_div_q) begin
            if (div_trial[WIDTH]) begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {lo_q[WIDTH-2:0], 1'b0};
            end else begin
                step_hi = div_trial[WIDTH-1:0];
                step_lo = {lo_q[WIDTH-2:0], 1'b1};
            end
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        if (i_load) begin
            hi_d     = '0;
            lo_d     = i_is_div ? i_a : i_b;
            opnd_d   = i_is_div ? i_b : i_a;
            cnt_d    = CW'(WIDTH);
            is_div_d = i_is_div;
        end else if (cnt_q != '0) begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
        end else begin
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
        end
    end

    // Results of the step in progress, so the caller can capture the final one.
    assign o_last   = (cnt_q == CW'(1));
    assign o_is_div = is_div_q;
    assign o_res_lo = step_lo;
    assign o_res_hi = step_hi;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle arithmetic/logic ops plus iterative MUL/DIV.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned OP_W  = ALU_OP_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [OP_W-1:0]  i_operation,
    input  logic [WIDTH-1:0] i_src1,
    input  logic [WIDTH-1:0] i_src2,
    input  logic             i_srcC,
    input  logic             i_srcAc,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_des1,
    output logic [WIDTH-1:0] o_des2,
    output logic             o_desC,
    output logic             o_desAc,
    output logic             o_desOv
);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] des1_q, des1_d, des2_q, des2_d;
    logic             c_q, c_d, ac_q, ac_d, ov_q, ov_d;

    logic             is_sub, cin, start_iter, op_div, md_load;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum_full;
    logic [WIDTH-1:0] alu_lo, alu_hi;
    logic             alu_c, alu_ac, alu_ov;
    logic             md_last, md_is_div;
    logic [WIDTH-1:0] md_lo, md_hi;
    logic             unused_srcac;

    assign unused_srcac = i_srcAc;

    assign op_div     = (i_operation == ALU_CS_DIV);
    assign start_iter = (i_operation == ALU_CS_MUL) || (op_div && (i_src2 != '0));

    // SUB runs as A + ~B + ~C; inverting the raw carries turns them into borrows.
    // Internal carries are recovered from sum ^ a ^ b at the bit above.
    always_comb begin
        is_sub = (i_operation == ALU_CS_SUB);
        addend = is_sub ? ~i_src2 : i_src2;
        cin    = 1'b0;
        if (i_operation == ALU_CS_ADDC) cin = i_srcC;
        if (is_sub)                     cin = ~i_srcC;
        sum_full = {1'b0, i_src1} + {1'b0, addend} + {{WIDTH{1'b0}}, cin};

        alu_lo = i_src1;
        alu_hi = '0;
        alu_c  = 1'b0;
        alu_ac = 1'b0;
        alu_ov = 1'b0;
        case (i_operation)
            ALU_CS_ADD, ALU_CS_ADDC, ALU_CS_SUB: begin
                alu_lo = sum_full[WIDTH-1:0];
                alu_c  = sum_full[WIDTH] ^ is_sub;
                alu_ac = sum_full[4] ^ i_src1[4] ^ addend[4] ^ is_sub;
                alu_ov = sum_full[WIDTH]
                         ^ (sum_full[WIDTH-1] ^ i_src1[WIDTH-1] ^ addend[WIDTH-1]);
            end
            ALU_CS_AND:      alu_lo = i_src1 & i_src2;
            ALU_CS_OR:       alu_lo = i_src1 | i_src2;
            ALU_CS_XOR:      alu_lo = i_src1 ^ i_src2;
            ALU_CS_SHIFT_OP: alu_lo = i_src2;
            ALU_CS_DIV: begin
                alu_lo = '1;
                alu_hi = i_src1;
                alu_ov = 1'b1;
            end
            default: ;
        endcase
    end

    seq_alu_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (md_load),
        .i_is_div (op_div),
        .i_a      (i_src1),
        .i_b      (i_src2),
        .o_last   (md_last),
        .o_is_div (md_is_div),
        .o_res_lo (md_lo),
        .o_res_hi (md_hi)
    );

    always_comb begin
        state_d = state_q;
        md_load = 1'b0;
        des1_d  = des1_q;
        des2_d  = des2_q;
        c_d     = c_q;
        ac_d    = ac_q;
        ov_d    = ov_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    if (start_iter) begin
                        state_d = ST_ITER;
                        md_load = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                        des1_d  = alu_lo;
                        des2_d  = alu_hi;
                        c_d     = alu_c;
                        ac_d    = alu_ac;
                        ov_d    = alu_ov;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ITER: begin
                if (md_last) begin
                    state_d = ST_DONE;
                    des1_d  = md_lo;
                    des2_d  = md_hi;
                    c_d     = 1'b0;
                    ac_d    = 1'b0;
                    ov_d    = ~md_is_div & (md_hi != '0);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            des1_q  <= '0;
            des2_q  <= '0;
            c_q     <= 1'b0;
            ac_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            des1_q  <= des1_d;
            des2_q  <= des2_d;
            c_q     <= c_d;
            ac_q    <= ac_d;
            ov_q    <= ov_d;
        end
    end

    assign o_busy  = (state_q == ST_ITER);
    assign o_done  = (state_q == ST_DONE);
    assign o_des1  = des1_q;
    assign o_des2  = des2_q;
    assign o_desC  = c_q;
    assign o_desAc = ac_q;
    assign o_desOv = ov_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=8): vector table, scoreboard queue, corner sequences.
module tb_seq_alu;
    import seq_alu_pkg::*;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_start;
    logic [3:0] i_operation;
    logic [7:0] i_src1, i_src2;
    logic       i_srcC, i_srcAc;
    logic       o_busy, o_done;
    logic [7:0] o_des1, o_des2;
    logic       o_desC, o_desAc, o_desOv;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a, b;
        logic       c;
        logic [7:0] d1, d2;
        logic       ec, eac, eov;
        int         lat;
    } vec_t;

    typedef struct {
        logic [7:0] d1, d2;
        logic       ec, eac, eov;
        int         lat;
    } exp_t;

    vec_t vecs[19];
    exp_t sb[$];

    seq_alu #(
        .WIDTH (8),
        .OP_W  (4)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_operation (i_operation),
        .i_src1      (i_src1),
        .i_src2      (i_src2),
        .i_srcC      (i_srcC),
        .i_srcAc     (i_srcAc),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_des1      (o_des1),
        .o_des2      (o_des2),
        .o_desC      (o_desC),
        .o_desAc     (o_desAc),
        .o_desOv     (o_desOv)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic compare_result(input string tag, input int lat, input int busy_cnt, input int exp_busy);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, " scoreboard_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({tag, " done"},    32'(o_done),  32'd1);
        check({tag, " latency"}, 32'(lat),     32'(e.lat));
        check({tag, " busy"},    32'(busy_cnt), 32'(exp_busy));
        check({tag, " des1"},    32'(o_des1),  32'(e.d1));
        check({tag, " des2"},    32'(o_des2),  32'(e.d2));
        check({tag, " C"},       32'(o_desC),  32'(e.ec));
        check({tag, " Ac"},      32'(o_desAc), 32'(e.eac));
        check({tag, " Ov"},      32'(o_desOv), 32'(e.eov));
    endtask

    // Called #1 after start edge N; counts edges until o_done is seen.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        while (!o_done && lat < 40) begin
            if (o_busy) busy_cnt++;
            @(posedge i_clk); #1;
            lat++;
        end
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.d1 = v.d1; e.d2 = v.d2; e.ec = v.ec; e.eac = v.eac; e.eov = v.eov; e.lat = v.lat;
        sb.push_back(e);
    endtask

    task automatic drive(input vec_t v);
        i_operation = v.op;
        i_src1      = v.a;
        i_src2      = v.b;
        i_srcC      = v.c;
        i_srcAc     = 1'($urandom);
        i_start     = 1'b1;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int lat, busy_cnt;
        @(negedge i_clk);
        drive(v);
        push_exp(v);
        @(posedge i_clk); #1;
        i_start = 1'b0;
        wait_done(lat, busy_cnt);
        compare_result(tag, lat, busy_cnt, v.lat);
    endtask

    initial begin
        int lat, busy_cnt, dones;
        vec_t v;

        vecs[0]  = '{ALU_CS_ADD,      8'h7F, 8'h01, 1'b0, 8'h80, 8'h00, 1'b0, 1'b1, 1'b1, 0};
        vecs[1]  = '{ALU_CS_SUB,      8'h00, 8'h01, 1'b1, 8'hFE, 8'h00, 1'b1, 1'b1, 1'b0, 0};
        vecs[2]  = '{ALU_CS_MUL,      8'h50, 8'hA0, 1'b0, 8'h00, 8'h32, 1'b0, 1'b0, 1'b1, 8};
        vecs[3]  = '{ALU_CS_DIV,      8'hFB, 8'h12, 1'b0, 8'h0D, 8'h11, 1'b0, 1'b0, 1'b0, 8};
        vecs[4]  = '{ALU_CS_DIV,      8'h42, 8'h00, 1'b0, 8'hFF, 8'h42, 1'b0, 1'b0, 1'b1, 0};
        vecs[5]  = '{ALU_CS_ADD,      8'hFF, 8'h01, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 0};
        vecs[6]  = '{ALU_CS_ADDC,     8'hFF, 8'h00, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 0};
        vecs[7]  = '{ALU_CS_ADDC,     8'h40, 8'h3F, 1'b1, 8'h80, 8'h00, 1'b0, 1'b1, 1'b1, 0};
        vecs[8]  = '{ALU_CS_SUB,      8'h80, 8'h01, 1'b0, 8'h7F, 8'h00, 1'b0, 1'b1, 1'b1, 0};
        vecs[9]  = '{ALU_CS_AND,      8'hF0, 8'h3C, 1'b1, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 0};
        vecs[10] = '{ALU_CS_OR,       8'hF0, 8'h0F, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 0};
        vecs[11] = '{ALU_CS_XOR,      8'hAA, 8'hFF, 1'b0, 8'h55, 8'h00, 1'b0, 1'b0, 1'b0, 0};
        vecs[12] = '{ALU_CS_SHIFT_OP, 8'h12, 8'h34, 1'b1, 8'h34, 8'h00, 1'b0, 1'b0, 1'b0, 0};
        vecs[13] = '{ALU_CS_NOP,      8'h12, 8'h34, 1'b1, 8'h12, 8'h00, 1'b0, 1'b0, 1'b0, 0};
        vecs[14] = '{4'hF,            8'h5A, 8'hA5, 1'b1, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, 0};
        vecs[15] = '{ALU_CS_MUL,      8'hFF, 8'hFF, 1'b0, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b1, 8};
        vecs[16] = '{ALU_CS_MUL,      8'h0F, 8'h03, 1'b1, 8'h2D, 8'h00, 1'b0, 1'b0, 1'b0, 8};
        vecs[17] = '{ALU_CS_DIV,      8'h07, 8'h09, 1'b0, 8'h00, 8'h07, 1'b0, 1'b0, 1'b0, 8};
        vecs[18] = '{ALU_CS_DIV,      8'hFF, 8'h01, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 8};

        i_rst = 1'b1; i_start = 1'b0; i_operation = '0;
        i_src1 = '0; i_src2 = '0; i_srcC = 1'b0; i_srcAc = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check("reset ctrl", 32'({o_busy, o_done, o_desC, o_desAc, o_desOv}), 32'd0);
        check("reset des1", 32'(o_des1), 32'd0);
        check("reset des2", 32'(o_des2), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (2) @(posedge i_clk);

        for (int i = 0; i < 19; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Start of an ADD while MUL is iterating must be dropped.
        @(negedge i_clk);
        v = vecs[2];
        drive(v);
        push_exp(v);
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        i_operation = ALU_CS_ADD; i_src1 = 8'h01; i_src2 = 8'h01; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        wait_done(lat, busy_cnt);
        compare_result("mul_ignore", lat + 4, busy_cnt + 4, 8);
        @(posedge i_clk); #1;
        check("mul_ignore no_queue", 32'({o_busy, o_done}), 32'd0);

        // Back-to-back: new start while o_done is high.
        @(negedge i_clk);
        v = '{ALU_CS_ADD, 8'h01, 8'h02, 1'b0, 8'h03, 8'h00, 1'b0, 1'b0, 1'b0, 0};
        drive(v);
        push_exp(v);
        @(posedge i_clk); #1;
        compare_result("b2b first", 0, 0, 0);
        v = '{ALU_CS_XOR, 8'h0F, 8'hF0, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 0};
        drive(v);
        push_exp(v);
        @(posedge i_clk); #1;
        i_start = 1'b0;
        compare_result("b2b second", 0, 0, 0);
        @(posedge i_clk); #1;
        check("b2b done_drops", 32'(o_done), 32'd0);

        // Reset during MUL iteration 4: outputs clear at once, no o_done ever.
        @(negedge i_clk);
        drive(vecs[2]);
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (4) @(posedge i_clk);
        #2;
        check("pre_reset busy", 32'(o_busy), 32'd1);
        i_rst = 1'b1;
        #1;
        check("mid_reset ctrl", 32'({o_busy, o_done, o_desC, o_desAc, o_desOv}), 32'd0);
        check("mid_reset des1", 32'(o_des1), 32'd0);
        check("mid_reset des2", 32'(o_des2), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge i_clk); #1;
            if (o_done || o_busy) dones++;
        end
        check("post_reset no_done", 32'(dones), 32'd0);
        run_vec("after_reset add", '{ALU_CS_ADD, 8'h10, 8'h20, 1'b1, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 0});

        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
